// File: rtl/quad_encoder_gen.sv
// Quadrature A/B generator driven by step commands, with optional contact chatter
// after each settled edge. Tracks net settled transitions in a wrapping position counter.
module quad_encoder_gen #(
    parameter int CNT_W = 8,
    parameter int PER_W = 16,
    parameter int BNC_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic [PER_W-1:0] cmd_period,
    input  logic [BNC_W-1:0] cmd_bounce,
    input  logic             abort,
    output logic             enc_a,
    output logic             enc_b,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] position
);

    localparam int CHW = BNC_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_EDGE,
        S_CHAT,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [PER_W-1:0] cnt, cnt_nxt;
    logic [PER_W-1:0] period_l, period_nxt;
    logic [CNT_W-1:0] steps_left, steps_nxt;
    logic [BNC_W-1:0] bounce_l, bounce_nxt;
    logic             dir_l, dir_nxt;
    logic [1:0]       phase, phase_nxt;
    logic             a_nxt, b_nxt;
    logic             chat_a, chat_a_nxt;
    logic [CHW-1:0]   chat_cnt, chat_cnt_nxt;
    logic [CNT_W-1:0] pos_nxt;
    logic             abort_seen, abort_nxt;
    logic             do_step, do_exit;
    logic [1:0]       step_phase;
    logic [1:0]       step_ab;
    logic [PER_W-1:0] period_eff;

    // Phase index 0..3 maps onto the (A,B) Gray sequence 00,10,11,01.
    function automatic logic [1:0] gray_of(input logic [1:0] q);
        case (q)
            2'd0:    gray_of = 2'b00;
            2'd1:    gray_of = 2'b10;
            2'd2:    gray_of = 2'b11;
            default: gray_of = 2'b01;
        endcase
    endfunction

    assign cmd_ready  = (state == S_IDLE);
    assign busy       = ~cmd_ready;
    assign done       = (state == S_DONE);
    assign period_eff = (cmd_period == '0) ? PER_W'(1) : cmd_period;
    assign step_phase = dir_l ? phase + 2'd1 : phase - 2'd1;
    assign step_ab    = gray_of(step_phase);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            period_l   <= '0;
            steps_left <= '0;
            bounce_l   <= '0;
            dir_l      <= 1'b0;
            phase      <= 2'd0;
            enc_a      <= 1'b0;
            enc_b      <= 1'b0;
            chat_a     <= 1'b0;
            chat_cnt   <= '0;
            position   <= '0;
            abort_seen <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            period_l   <= period_nxt;
            steps_left <= steps_nxt;
            bounce_l   <= bounce_nxt;
            dir_l      <= dir_nxt;
            phase      <= phase_nxt;
            enc_a      <= a_nxt;
            enc_b      <= b_nxt;
            chat_a     <= chat_a_nxt;
            chat_cnt   <= chat_cnt_nxt;
            position   <= pos_nxt;
            abort_seen <= abort_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        period_nxt   = period_l;
        steps_nxt    = steps_left;
        bounce_nxt   = bounce_l;
        dir_nxt      = dir_l;
        phase_nxt    = phase;
        a_nxt        = enc_a;
        b_nxt        = enc_b;
        chat_a_nxt   = chat_a;
        chat_cnt_nxt = chat_cnt;
        pos_nxt      = position;
        abort_nxt    = abort_seen | abort;
        do_step      = 1'b0;
        do_exit      = 1'b0;

        case (state)
            S_IDLE: begin
                abort_nxt = 1'b0;
                if (cmd_valid) begin
                    dir_nxt    = cmd_dir;
                    steps_nxt  = cmd_steps;
                    period_nxt = period_eff;
                    bounce_nxt = cmd_bounce;
                    cnt_nxt    = period_eff;
                    state_nxt  = (cmd_steps == '0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort || abort_seen) begin
                    state_nxt = S_DONE;
                end else if (cnt == PER_W'(1)) begin
                    do_step = 1'b1;
                end else begin
                    cnt_nxt = cnt - PER_W'(1);
                end
            end
            S_EDGE: begin
                if (bounce_l != '0) begin
                    if (chat_a) a_nxt = ~enc_a;
                    else        b_nxt = ~enc_b;
                    chat_cnt_nxt = {bounce_l, 1'b0} - CHW'(1);
                    state_nxt    = S_CHAT;
                end else begin
                    do_exit = 1'b1;
                end
            end
            S_CHAT: begin
                if (chat_cnt != '0) begin
                    if (chat_a) a_nxt = ~enc_a;
                    else        b_nxt = ~enc_b;
                    chat_cnt_nxt = chat_cnt - CHW'(1);
                end else begin
                    do_exit = 1'b1;
                end
            end
            S_DONE: begin
                abort_nxt = 1'b0;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        // The exit cycle counts as the first cycle of the next period, hence P-1
        // reload; with P=1 the next edge fires straight away.
        if (do_exit) begin
            if (steps_left == '0 || abort || abort_seen) begin
                state_nxt = S_DONE;
            end else if (period_l == PER_W'(1)) begin
                do_step = 1'b1;
            end else begin
                cnt_nxt   = period_l - PER_W'(1);
                state_nxt = S_WAIT;
            end
        end

        if (do_step) begin
            phase_nxt  = step_phase;
            a_nxt      = step_ab[1];
            b_nxt      = step_ab[0];
            chat_a_nxt = (step_ab[1] != enc_a);
            pos_nxt    = dir_l ? position + CNT_W'(1) : position - CNT_W'(1);
            steps_nxt  = steps_left - CNT_W'(1);
            state_nxt  = S_EDGE;
        end
    end

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Directed bench for quad_encoder_gen: table of commands with hand-computed timing and
// positions, an independent quadrature decoder, plus chatter and mid-command reset sequences.
module tb_quad_encoder_gen;
    localparam int CNT_W = 8;
    localparam int PER_W = 16;
    localparam int BNC_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic             cmd_dir = 1'b0;
    logic [CNT_W-1:0] cmd_steps = '0;
    logic [PER_W-1:0] cmd_period = '0;
    logic [BNC_W-1:0] cmd_bounce = '0;
    logic             abort = 1'b0;
    logic             enc_a, enc_b, busy, done;
    logic [CNT_W-1:0] position;

    quad_encoder_gen #(.CNT_W(CNT_W), .PER_W(PER_W), .BNC_W(BNC_W)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period),
        .cmd_bounce(cmd_bounce), .abort(abort), .enc_a(enc_a), .enc_b(enc_b),
        .busy(busy), .done(done), .position(position)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         do_reset;
        bit         dir;
        int         steps;
        int         period;
        int         bounce;
        int         abort_at;
        int         exp_first;
        logic [1:0] exp_first_ab;
        int         exp_done;
        int         exp_pos;
        logic [1:0] exp_ab;
        int         exp_net;
    } vec_t;

    vec_t       tbl[11];
    vec_t       post;
    int         checks = 0;
    int         fails = 0;
    int         net = 0;
    int         illegal = 0;
    int         delta;
    logic [1:0] last_ab = 2'b00;

    function automatic int idx_of(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // Naive decoder: chatter toggles cancel in pairs, so net equals settled transitions.
    always @(negedge clk) begin
        if (!reset) begin
            last_ab = 2'b00;
        end else if ({enc_a, enc_b} != last_ab) begin
            delta = (idx_of({enc_a, enc_b}) - idx_of(last_ab) + 4) % 4;
            if (delta == 1)      net = net + 1;
            else if (delta == 3) net = net - 1;
            else                 illegal = illegal + 1;
            last_ab = {enc_a, enc_b};
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic doReset();
        reset = 1'b0;
        #2;
        checkOutput("reset enc_a", enc_a, 0);
        checkOutput("reset enc_b", enc_b, 0);
        checkOutput("reset position", position, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset cmd_ready", cmd_ready, 1);
        checkOutput("reset busy", busy, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic startCmd(input bit dir, input int steps, input int period, input int bounce);
        cmd_dir    = dir;
        cmd_steps  = CNT_W'(steps);
        cmd_period = PER_W'(period);
        cmd_bounce = BNC_W'(bounce);
        cmd_valid  = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid  = 1'b0;
        cmd_steps  = CNT_W'($urandom);
        cmd_period = PER_W'($urandom);
        cmd_bounce = BNC_W'($urandom);
        cmd_dir    = 1'($urandom);
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        int         first;
        int         done_at;
        int         net0;
        logic [1:0] prev;
        logic [1:0] first_ab;
        if (v.do_reset) doReset();
        checkOutput({tag, " ready before"}, cmd_ready, 1);
        net0     = net;
        prev     = {enc_a, enc_b};
        first    = -1;
        first_ab = 2'b00;
        done_at  = -1;
        startCmd(v.dir, v.steps, v.period, v.bounce);
        checkOutput({tag, " busy"}, busy, 1);
        for (int j = 0; j < 3000; j++) begin
            if (j > 0) begin
                @(posedge clk);
                #1;
            end
            if (j == v.abort_at) abort = 1'b1;
            if (first < 0 && {enc_a, enc_b} != prev) begin
                first    = j;
                first_ab = {enc_a, enc_b};
            end
            if (done) begin
                done_at = j;
                break;
            end
        end
        abort = 1'b0;
        checkOutput({tag, " first edge cycle"}, first, v.exp_first);
        checkOutput({tag, " first edge AB"}, first_ab, v.exp_first_ab);
        checkOutput({tag, " done cycle"}, done_at, v.exp_done);
        checkOutput({tag, " position"}, position, v.exp_pos);
        checkOutput({tag, " final AB"}, {enc_a, enc_b}, v.exp_ab);
        checkOutput({tag, " decoded net"}, net - net0, v.exp_net);
        @(posedge clk);
        #1;
        checkOutput({tag, " done width"}, done, 0);
        checkOutput({tag, " ready after"}, cmd_ready, 1);
    endtask

    task automatic midReset(input string tag, input int cycles, input logic [1:0] exp_ab);
        bit saw_done;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
        checkOutput({tag, " busy before"}, busy, 1);
        checkOutput({tag, " position before"}, position, 1);
        checkOutput({tag, " AB before"}, {enc_a, enc_b}, exp_ab);
        #2;
        reset = 1'b0;
        #1;
        checkOutput({tag, " enc_a"}, enc_a, 0);
        checkOutput({tag, " enc_b"}, enc_b, 0);
        checkOutput({tag, " position"}, position, 0);
        checkOutput({tag, " cmd_ready"}, cmd_ready, 1);
        saw_done = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        if (done) saw_done = 1'b1;
        checkOutput({tag, " no done"}, saw_done, 0);
    endtask

    initial begin
        logic [6:0] chat_a_seq;

        //          rst dir  st  per bnc  abt first fAB    done pos  AB     net
        tbl[0]  = '{1, 1'b1, 4,  3,  0,  -1,  3,  2'b10, 13,  4,   2'b00,  4};
        tbl[1]  = '{1, 1'b0, 3,  2,  0,  -1,  2,  2'b01, 7,   253, 2'b10, -3};
        tbl[2]  = '{1, 1'b1, 1,  1,  2,  -1,  1,  2'b10, 6,   1,   2'b10,  1};
        tbl[3]  = '{0, 1'b0, 2,  0,  0,  -1,  1,  2'b00, 3,   255, 2'b01, -2};
        tbl[4]  = '{0, 1'b1, 2,  2,  1,  -1,  2,  2'b00, 9,   1,   2'b10,  2};
        tbl[5]  = '{0, 1'b0, 0,  7,  5,  -1, -1,  2'b00, 0,   1,   2'b10,  0};
        tbl[6]  = '{0, 1'b0, 5,  4,  0,  -1,  4,  2'b00, 21,  252, 2'b00, -5};
        tbl[7]  = '{0, 1'b1, 10, 5,  0,  12,  5,  2'b10, 13,  254, 2'b11,  2};
        tbl[8]  = '{0, 1'b1, 5,  2,  2,  3,   2,  2'b01, 7,   255, 2'b01,  1};
        tbl[9]  = '{0, 1'b1, 20, 64, 3,  -1,  64, 2'b00, 1401, 19, 2'b01, 20};
        tbl[10] = '{0, 1'b0, 20, 64, 3,  -1,  64, 2'b11, 1401, 255, 2'b01, -20};
        post    = '{0, 1'b1, 2,  1,  0,  -1,  1,  2'b10, 3,   2,   2'b11,  2};

        doReset();
        for (int i = 0; i < 11; i++) applyStimulus(tbl[i], $sformatf("vec%0d", i));

        // Chatter on A after a single rising edge: A = 0,1,0,1,0,1,1 for cycles 0..6.
        doReset();
        chat_a_seq = 7'b1101010;
        startCmd(1'b1, 1, 1, 2);
        for (int j = 0; j < 7; j++) begin
            if (j > 0) begin
                @(posedge clk);
                #1;
            end
            checkOutput($sformatf("chatter A cyc%0d", j), enc_a, chat_a_seq[j]);
            checkOutput($sformatf("chatter B cyc%0d", j), enc_b, 0);
            checkOutput($sformatf("chatter done cyc%0d", j), done, (j == 6) ? 1 : 0);
        end
        checkOutput("chatter position", position, 1);
        @(posedge clk);
        #1;

        // Reset dropped mid-WAIT (after first edge) and mid-CHAT, then a clean command.
        doReset();
        startCmd(1'b1, 10, 8, 0);
        midReset("midwait", 11, 2'b10);
        startCmd(1'b1, 3, 2, 3);
        midReset("midchat", 4, 2'b10);
        applyStimulus(post, "post-reset");

        checkOutput("illegal AB transitions", illegal, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
